// File: rtl/alu_req_arbiter.sv
`timescale 1ns/1ps
// Shares one ALU between two requesters with round-robin arbitration. One op is in
// flight at a time, and its result is returned with the requester id over a valid/ready channel.
module alu_req_arbiter #(
  parameter int WIDTH      = 64,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_DIV = 5'b10010;
  localparam logic [4:0] OP_REM = 5'b10100;
  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic [CW-1:0]    cnt;
  logic             gnt_valid;
  logic             gnt_id;
  logic [4:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;
  logic             sel_divz;
  logic             exec_done;

  function automatic logic op_legal(input logic [4:0] op);
    return (op <= 5'b01110) || (op == 5'b10000) || (op == 5'b10001) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_multi(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // When both requesters contend, rr_ptr picks the winner; a lone requester always wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = rr_ptr;
      end else if (req0_valid || req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = req1_valid;
      end
    end
  end

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid && gnt_id;
  assign sel_op     = gnt_id ? req1_opcode : req0_opcode;
  assign sel_a      = gnt_id ? req1_a : req0_a;
  assign sel_b      = gnt_id ? req1_b : req0_b;
  assign sel_legal  = op_legal(sel_op);
  assign sel_divz   = ((sel_op == OP_DIV) || (sel_op == OP_REM)) && (sel_b == '0);
  assign exec_done  = !op_multi(alu_opcode) || (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (!sel_legal || sel_divz) state_nxt = RESP;
          else                        state_nxt = EXEC;
        end
      end
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Errors are resolved at accept time so they skip the ALU; illegal opcodes leave alu_* untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            rr_ptr <= ~gnt_id;
            rsp_id <= gnt_id;
            cnt    <= '0;
            if (!sel_legal) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end else begin
              alu_opcode <= sel_op;
              alu_a      <= sel_a;
              alu_b      <= sel_b;
              if (sel_divz) begin
                rsp_err  <= 1'b1;
                rsp_data <= (sel_op == OP_DIV) ? '1 : sel_a;
              end
            end
          end
        end
        EXEC: begin
          if (exec_done) begin
            rsp_data <= alu_y;
            rsp_err  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_req_arbiter: an ALU model with real multi-cycle latency,
// a transaction-level arbitration model, and a decoupled response monitor.
module tb_alu_req_arbiter;

  localparam int WIDTH = 64;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]       req0_opcode, req1_opcode, alu_opcode;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_y;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  alu_req_arbiter #(.WIDTH(WIDTH), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [63:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          seen = 0;
  bit          m_idle = 1;
  logic        m_rr = 0;
  logic [4:0]  m_op = '0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;
  logic        slot_v [2];
  logic [4:0]  slot_op [2];
  logic [63:0] slot_a [2];
  logic [63:0] slot_b [2];
  int          rdy_pct = 100;
  int          hold_cnt = 0;

  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << b[5:0];
      5'd6:    return a >> b[5:0];
      5'd7:    return 64'($signed(a) >>> b[5:0]);
      5'd8:    return {63'd0, $signed(a) < $signed(b)};
      5'd9:    return {63'd0, a < b};
      5'd10:   return ~a;
      5'd11:   return b;
      5'd12:   return a * b;
      5'd13:   return a + 64'd1;
      5'd14:   return a - 64'd1;
      5'd16:   return (a < b) ? a : b;
      5'd17:   return (a < b) ? b : a;
      5'd18:   return (b == 64'd0) ? 64'd0 : a / b;
      5'd20:   return (b == 64'd0) ? 64'd0 : a % b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [4:0] op);
    return op inside {[5'd0:5'd14], 5'd16, 5'd17, 5'd18, 5'd20};
  endfunction

  function automatic bit ref_multi(input logic [4:0] op);
    return op inside {5'd12, 5'd18, 5'd20};
  endfunction

  // The ALU only produces a real MUL/DIV/REM result once its inputs have been held long enough.
  int unsigned age = 0;
  always @(posedge clk) begin
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) age <= 0;
    else age <= age + 1;
  end
  assign alu_y = (ref_multi(alu_opcode) && age < LAT - 1) ? 64'hBAD0_BAD0_BAD0_BAD0
                                                          : alu_fn(alu_opcode, alu_a, alu_b);

  function automatic exp_t predict(input logic id, input logic [4:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int unsigned c);
    exp_t r;
    r.id = id;
    if (!ref_legal(op)) begin
      r.data = 64'd0; r.err = 1'b1; r.due = c + 1;
    end else if ((op == 5'd18 || op == 5'd20) && b == 64'd0) begin
      r.data = (op == 5'd18) ? ~64'd0 : a; r.err = 1'b1; r.due = c + 1;
    end else begin
      r.data = alu_fn(op, a, b); r.err = 1'b0;
      r.due  = c + (ref_multi(op) ? LAT + 1 : 2);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic loadSlot(input int i, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b);
    slot_v[i] = 1'b1; slot_op[i] = op; slot_a[i] = a; slot_b[i] = b;
  endtask

  // One clock of stimulus plus the per-cycle checks of grant, busy and ALU operand registers.
  task automatic applyStimulus();
    logic g_any, g_id;
    @(posedge clk); #1;
    req0_valid = slot_v[0]; req0_opcode = slot_op[0]; req0_a = slot_a[0]; req0_b = slot_b[0];
    req1_valid = slot_v[1]; req1_opcode = slot_op[1]; req1_a = slot_a[1]; req1_b = slot_b[1];
    if (hold_cnt > 0) begin
      rsp_ready = 1'b0;
      hold_cnt--;
    end else begin
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    end
    #2;
    checkOutput("busy", 64'(busy), 64'(!m_idle));
    checkOutput("alu_opcode", 64'(alu_opcode), 64'(m_op));
    checkOutput("alu_a", alu_a, m_a);
    checkOutput("alu_b", alu_b, m_b);
    g_any = m_idle && (slot_v[0] || slot_v[1]);
    g_id  = (slot_v[0] && slot_v[1]) ? m_rr : slot_v[1];
    checkOutput("req0_ready", 64'(req0_ready), 64'(g_any && !g_id));
    checkOutput("req1_ready", 64'(req1_ready), 64'(g_any && g_id));
    if (g_any) begin
      sb.push_back(predict(g_id, slot_op[g_id], slot_a[g_id], slot_b[g_id], cyc));
      if (ref_legal(slot_op[g_id])) begin
        m_op = slot_op[g_id]; m_a = slot_a[g_id]; m_b = slot_b[g_id];
      end
      m_rr = !g_id;
      m_idle = 0;
      slot_v[g_id] = 1'b0;
    end
  endtask

  task automatic waitIdle(input int max);
    int n = 0;
    while ((!m_idle || sb.size() != 0 || slot_v[0] || slot_v[1]) && n < max) begin
      applyStimulus();
      n++;
    end
    if (!m_idle || sb.size() != 0 || slot_v[0] || slot_v[1]) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", max);
    end
  endtask

  task automatic doReset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    slot_v[0] = 1'b0; slot_v[1] = 1'b0;
    sb.delete(); seen = 0; m_idle = 1; m_rr = 1'b0;
    m_op = '0; m_a = '0; m_b = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset_rsp_data", rsp_data, 64'd0);
    checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("reset_alu_opcode", 64'(alu_opcode), 64'd0);
    checkOutput("reset_alu_a", alu_a, 64'd0);
    checkOutput("reset_alu_b", alu_b, 64'd0);
  endtask

  // Monitor: compares every cycle the response is presented and retires it on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL rsp_unexpected: rsp_valid=1 id=%0d data=%h, expected no response",
                   rsp_id, rsp_data);
        end else begin
          e = sb[0];
          if (!seen) begin
            checkOutput("rsp_latency_cycle", 64'(cyc), 64'(e.due));
            seen = 1;
          end
          checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
          checkOutput("rsp_data", rsp_data, e.data);
          checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready) begin
            void'(sb.pop_front());
            seen = 0;
            m_idle = 1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
    slot_v[0] = 1'b0; slot_v[1] = 1'b0;
    doReset(3);

    $display("[TB] single ADD on req0");
    loadSlot(0, 5'd0, 64'd5, 64'd7);
    applyStimulus();
    waitIdle(20);

    $display("[TB] contention, SUB 10-3 on both requesters");
    for (int i = 0; i < 24; i++) begin
      if (!slot_v[0]) loadSlot(0, 5'd1, 64'd10, 64'd3);
      if (!slot_v[1]) loadSlot(1, 5'd1, 64'd10, 64'd3);
      applyStimulus();
    end
    waitIdle(40);

    $display("[TB] multi-cycle MUL on req1");
    loadSlot(1, 5'b01100, 64'd6, 64'd7);
    waitIdle(30);

    $display("[TB] error paths");
    loadSlot(0, 5'b10011, {$urandom, $urandom}, {$urandom, $urandom});
    waitIdle(20);
    loadSlot(0, 5'b10010, 64'd9, 64'd0);
    waitIdle(20);
    loadSlot(1, 5'b10100, 64'd9, 64'd0);
    waitIdle(20);

    $display("[TB] backpressure with req1 waiting");
    loadSlot(0, 5'd0, 64'd1, 64'd2);
    applyStimulus();
    loadSlot(1, 5'd1, 64'd20, 64'd5);
    hold_cnt = 6;
    waitIdle(40);

    $display("[TB] reset during MUL execution");
    loadSlot(0, 5'b01100, 64'd6, 64'd7);
    applyStimulus();
    applyStimulus();
    doReset(1);
    loadSlot(0, 5'd0, 64'd3, 64'd4);
    loadSlot(1, 5'd0, 64'd8, 64'd9);
    applyStimulus();
    waitIdle(30);

    $display("[TB] randomized traffic");
    rdy_pct = 70;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!slot_v[i] && $urandom_range(0, 99) < 40) begin
          logic [4:0]  op;
          logic [63:0] b;
          case ($urandom_range(0, 5))
            0:       op = 5'd12;
            1:       op = 5'd18;
            2:       op = 5'd20;
            default: op = 5'($urandom_range(0, 31));
          endcase
          b = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
          loadSlot(i, op, {$urandom, $urandom}, b);
        end
      end
      applyStimulus();
    end
    waitIdle(200);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
